cubic_fetch_seq: RTL

Sequencer and operand feeder directly upstream of the cubic interpolation engine in the scaler datapath. Accepts one interpolation request per handshake (integer pixel index + Q0.8 fraction), computes the Q0.8 power vector {t, t², t³}, fetches the four neighbour pixels P(-1..2) from a 1-cycle-latency line memory, and drives the engine's `cycle_cnt` cadence. Flags when the engine's 8-bit output holds a finished sample.

---
 rtl/cubic_fetch_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cubic_fetch_seq.sv
// Operand sequencer for the cubic interpolation engine: power vector, four-tap pixel fetch, phase cadence.
// Optional CUBIC_SEQ_EDGE_CLAMP_EN clamps neighbour indices to [0, LINE_LEN-1]; otherwise indices wrap.
module cubic_fetch_seq #(
  parameter int LINE_LEN = 200,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_idx,
  input  logic [7:0]        req_frac,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        cyc_cnt,
  output logic [23:0]       x_out,
  output logic [7:0]        p_out,
  output logic              res_valid,
  output logic [2:0]        state_dbg
);

  // Handshake: a request transfers on any clock edge where req_valid and req_ready are both high;
  // req_ready is high only in IDLE and C4, and the request fields are captured on that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_C0    = 3'd1,
    S_C1    = 3'd2,
    S_C2    = 3'd3,
    S_C3    = 3'd4,
    S_C4    = 3'd5,
    S_FLUSH = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx_r;
  logic              pending;
  logic              accept;
  logic [7:0]        t2, t3;
  logic [ADDR_W-1:0] rd_base, rd_off, rd_addr;
  logic              rd_en;
  logic [2:0]        cc_nxt;

  assign req_ready = (state == S_IDLE) || (state == S_C4);
  assign accept    = req_valid && req_ready;
  assign p_out     = mem_rdata;
  assign state_dbg = state;

  // Rounded Q0.8 products; t3 is built from the already-rounded t2.
  assign t2 = 8'((({8'd0, req_frac} * {8'd0, req_frac}) + 16'd128) >> 8);
  assign t3 = 8'((({8'd0, t2} * {8'd0, req_frac}) + 16'd128) >> 8);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_C0;
      S_C0:    state_nxt = S_C1;
      S_C1:    state_nxt = S_C2;
      S_C2:    state_nxt = S_C3;
      S_C3:    state_nxt = S_C4;
      S_C4:    state_nxt = accept ? S_C0 : S_FLUSH;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cc_nxt = 3'd7;
    case (state_nxt)
      S_C0, S_FLUSH: cc_nxt = 3'd0;
      S_C1:          cc_nxt = 3'd1;
      S_C2:          cc_nxt = 3'd2;
      S_C3:          cc_nxt = 3'd3;
      S_C4:          cc_nxt = 3'd4;
      default:       cc_nxt = 3'd7;
    endcase
  end

  // Read strobe/address are registered from the next state so they line up with C0..C3;
  // entering C0 the index is still on req_idx, not yet in idx_r.
  always_comb begin
    rd_en   = 1'b0;
    rd_base = idx_r;
    rd_off  = '0;
    case (state_nxt)
      S_C0: begin rd_en = 1'b1; rd_base = req_idx; rd_off = '1; end
      S_C1: begin rd_en = 1'b1; rd_off = '0; end
      S_C2: begin rd_en = 1'b1; rd_off = ADDR_W'(1); end
      S_C3: begin rd_en = 1'b1; rd_off = ADDR_W'(2); end
      default: rd_en = 1'b0;
    endcase
  end

`ifdef CUBIC_SEQ_EDGE_CLAMP_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);
  logic signed [ADDR_W+1:0] rd_sum;

  always_comb begin
    rd_sum = $signed({2'b00, rd_base}) + $signed({{2{rd_off[ADDR_W-1]}}, rd_off});
    if (rd_sum < 0)
      rd_addr = '0;
    else if (rd_sum > $signed({2'b00, LAST}))
      rd_addr = LAST;
    else
      rd_addr = rd_sum[ADDR_W-1:0];
  end
`else
  assign rd_addr = rd_base + rd_off;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc_cnt   <= 3'd7;
      x_out     <= '0;
      idx_r     <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cc_nxt;
      mem_rd  <= rd_en;
      if (rd_en) mem_addr <= rd_addr;
      if (accept) begin
        idx_r <= req_idx;
        x_out <= {req_frac, t2, t3};
      end
      // The engine's result for a sample is committed in the C0/FLUSH cycle that follows its C4.
      res_valid <= 1'b0;
      if (state == S_C4) begin
        pending <= 1'b1;
      end else if (state == S_C0 || state == S_FLUSH) begin
        pending   <= 1'b0;
        res_valid <= pending;
      end
    end
  end

endmodule
